// File: rtl/stdp_rule.sv
// stdp_rule: pair-based STDP learning endpoint for a single synapse.
// Pre/post interval counters implement nearest-neighbour pairing.
// Stage 1 captures a paired event (LTP or LTD) together with its interval.
// Stage 2 applies a shift-decayed amplitude to the weight and clamps the result.
module stdp_rule #(
    parameter int WEIGHT_W  = 8,
    parameter int TIME_W    = 6,
    parameter int WINDOW    = 32,
    parameter int TAU_SHIFT = 2,
    parameter int A_PLUS    = 16,
    parameter int A_MINUS   = 16,
    parameter int W_INIT    = 128,
    parameter int W_MAX     = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pre_spike,
    input  logic                post_spike,
    input  logic                learn_en,
    input  logic                w_load,
    input  logic [WEIGHT_W-1:0] w_load_val,
    output logic [WEIGHT_W-1:0] weight,
    output logic                update_valid,
    output logic                update_ltp,
    output logic [TIME_W-1:0]   last_dt
);

    localparam logic [TIME_W-1:0]   WIN_C     = TIME_W'(WINDOW);
    localparam logic [TIME_W:0]     WIN_X     = (TIME_W+1)'(WINDOW);
    localparam logic [WEIGHT_W-1:0] W_INIT_C  = WEIGHT_W'(W_INIT);
    localparam logic [WEIGHT_W-1:0] W_MAX_C   = WEIGHT_W'(W_MAX);
    localparam logic [WEIGHT_W:0]   W_MAX_X   = (WEIGHT_W+1)'(W_MAX);
    localparam logic [WEIGHT_W-1:0] A_PLUS_C  = WEIGHT_W'(A_PLUS);
    localparam logic [WEIGHT_W-1:0] A_MINUS_C = WEIGHT_W'(A_MINUS);

    // Next value of an interval counter: a spike restarts it, otherwise it
    // counts up and parks at WINDOW so that stale spikes never pair.
    function automatic logic [TIME_W-1:0] cnt_next(input logic spike,
                                                   input logic [TIME_W-1:0] cnt);
        if (spike) begin
            return {TIME_W{1'b0}};
        end else if (cnt < WIN_C) begin
            return cnt + {{(TIME_W-1){1'b0}}, 1'b1};
        end else begin
            return WIN_C;
        end
    endfunction

    // Exponential decay approximated by a right shift of the amplitude;
    // shifting by the full width or more yields zero.
    function automatic logic [WEIGHT_W-1:0] decay_delta(input logic [WEIGHT_W-1:0] amp,
                                                        input logic [TIME_W-1:0]   dt);
        logic [31:0] sh;
        sh = 32'(dt >> TAU_SHIFT);
        if (sh >= 32'(WEIGHT_W)) begin
            return {WEIGHT_W{1'b0}};
        end else begin
            return amp >> sh;
        end
    endfunction

    logic [TIME_W-1:0]   pre_cnt_r;
    logic [TIME_W-1:0]   post_cnt_r;
    logic                s1_valid_r;
    logic                s1_ltp_r;
    logic [TIME_W-1:0]   s1_dt_r;
    logic [WEIGHT_W-1:0] weight_r;
    logic                update_valid_r;
    logic                update_ltp_r;
    logic [TIME_W-1:0]   last_dt_r;

    logic [TIME_W:0]     pre_dt_s;
    logic [TIME_W:0]     post_dt_s;
    logic                cap_ltp_s;
    logic                cap_ltd_s;
    logic [WEIGHT_W-1:0] delta_s;
    logic [WEIGHT_W:0]   sum_s;
    logic [WEIGHT_W:0]   diff_s;
    logic [WEIGHT_W-1:0] w_next_s;

    // Pair detection: interval to the most recent opposite spike and event capture.
    always_comb begin
        pre_dt_s  = {1'b0, pre_cnt_r}  + {{TIME_W{1'b0}}, 1'b1};
        post_dt_s = {1'b0, post_cnt_r} + {{TIME_W{1'b0}}, 1'b1};
        cap_ltp_s = 1'b0;
        cap_ltd_s = 1'b0;
        if (learn_en && post_spike && !pre_spike) begin
            cap_ltp_s = (pre_dt_s < WIN_X);
        end else if (learn_en && pre_spike && !post_spike) begin
            cap_ltd_s = (post_dt_s < WIN_X);
        end else begin
            cap_ltp_s = 1'b0;
            cap_ltd_s = 1'b0;
        end
    end

    // Weight arithmetic with one guard bit so neither clamp can wrap.
    always_comb begin
        delta_s  = decay_delta(s1_ltp_r ? A_PLUS_C : A_MINUS_C, s1_dt_r);
        sum_s    = {1'b0, weight_r} + {1'b0, delta_s};
        diff_s   = {1'b0, weight_r} - {1'b0, delta_s};
        w_next_s = weight_r;
        if (s1_ltp_r) begin
            w_next_s = (sum_s > W_MAX_X) ? W_MAX_C : sum_s[WEIGHT_W-1:0];
        end else begin
            w_next_s = diff_s[WEIGHT_W] ? {WEIGHT_W{1'b0}} : diff_s[WEIGHT_W-1:0];
        end
    end

    // Interval counters: restart on own spike, saturate at WINDOW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_r  <= WIN_C;
            post_cnt_r <= WIN_C;
        end else begin
            pre_cnt_r  <= cnt_next(pre_spike, pre_cnt_r);
            post_cnt_r <= cnt_next(post_spike, post_cnt_r);
        end
    end

    // Stage 1: register a captured event; a weight load squashes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_ltp_r   <= 1'b0;
            s1_dt_r    <= {TIME_W{1'b0}};
        end else begin
            s1_valid_r <= (cap_ltp_s || cap_ltd_s) && !w_load;
            if (cap_ltp_s) begin
                s1_ltp_r <= 1'b1;
                s1_dt_r  <= pre_dt_s[TIME_W-1:0];
            end else if (cap_ltd_s) begin
                s1_ltp_r <= 1'b0;
                s1_dt_r  <= post_dt_s[TIME_W-1:0];
            end else begin
                s1_ltp_r <= s1_ltp_r;
                s1_dt_r  <= s1_dt_r;
            end
        end
    end

    // Stage 2: apply the update to the weight, or take a direct load instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_r       <= W_INIT_C;
            update_valid_r <= 1'b0;
            update_ltp_r   <= 1'b0;
            last_dt_r      <= {TIME_W{1'b0}};
        end else if (w_load) begin
            weight_r       <= w_load_val;
            update_valid_r <= 1'b0;
        end else if (s1_valid_r) begin
            weight_r       <= w_next_s;
            update_valid_r <= 1'b1;
            update_ltp_r   <= s1_ltp_r;
            last_dt_r      <= s1_dt_r;
        end else begin
            update_valid_r <= 1'b0;
        end
    end

    assign weight       = weight_r;
    assign update_valid = update_valid_r;
    assign update_ltp   = update_ltp_r;
    assign last_dt      = last_dt_r;

endmodule

// File: tb/tb_stdp_rule.sv
// tb_stdp_rule: directed scenarios for stdp_rule. Expected updates are pushed
// into a queue as each pairing spike is issued; a negedge monitor pops one
// entry per update_valid pulse and compares weight, direction and interval.
module tb_stdp_rule;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pre_spike = 1'b0;
    logic       post_spike = 1'b0;
    logic       learn_en = 1'b1;
    logic       w_load = 1'b0;
    logic [7:0] w_load_val = 8'd0;
    logic [7:0] weight;
    logic       update_valid;
    logic       update_ltp;
    logic [5:0] last_dt;

    typedef struct {
        int    w;
        int    ltp;
        int    dt;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    stdp_rule dut (
        .clk          (clk),
        .rst          (rst),
        .pre_spike    (pre_spike),
        .post_spike   (post_spike),
        .learn_en     (learn_en),
        .w_load       (w_load),
        .w_load_val   (w_load_val),
        .weight       (weight),
        .update_valid (update_valid),
        .update_ltp   (update_ltp),
        .last_dt      (last_dt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    // Monitor: every update pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && update_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_update", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_weight"}, int'(weight), e.w);
                chk({e.name, "_ltp"}, int'(update_ltp), e.ltp);
                chk({e.name, "_dt"}, int'(last_dt), e.dt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    task automatic expect_upd(input int w, input int ltp, input int dt, input string name);
        exp_t e;
        e.w = w; e.ltp = ltp; e.dt = dt; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        pre_spike = 1'b0; post_spike = 1'b0; w_load = 1'b0; learn_en = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gap(1);
    endtask

    task automatic pulse(input logic p, input logic q);
        pre_spike = p; post_spike = q;
        tick();
        pre_spike = 1'b0; post_spike = 1'b0;
    endtask

    task automatic load(input logic [7:0] v);
        w_load = 1'b1; w_load_val = v;
        tick();
        w_load = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_weight", int'(weight), 128);
        chk("rst_valid", int'(update_valid), 0);
        chk("rst_ltp", int'(update_ltp), 0);
        chk("rst_last_dt", int'(last_dt), 0);

        // LTP dt=3: delta 16 -> 144, pulse lasts exactly one cycle
        pulse(1'b1, 1'b0); gap(2);
        expect_upd(144, 1, 3, "ltp_dt3");
        pulse(1'b0, 1'b1);     // in cycle T+1
        tick();                // cycle T+2: update visible
        chk("ltp_dt3_pulse", int'(update_valid), 1);
        tick();
        chk("ltp_dt3_one_cycle", int'(update_valid), 0);
        chk("ltp_dt3_hold", int'(weight), 144);

        // LTD dt=8: delta 4 -> 124
        do_reset();
        pulse(1'b0, 1'b1); gap(7);
        expect_upd(124, 0, 8, "ltd_dt8");
        pulse(1'b1, 1'b0); gap(4);
        chk("ltd_dt8_weight", int'(weight), 124);

        // dt=32 is outside the window
        do_reset();
        pulse(1'b1, 1'b0); gap(31);
        pulse(1'b0, 1'b1); gap(4);
        chk("dt32_no_update", int'(weight), 128);

        // dt=35 with a saturated counter
        do_reset();
        pulse(1'b1, 1'b0); gap(34);
        pulse(1'b0, 1'b1); gap(4);
        chk("dt35_no_update", int'(weight), 128);

        // dt=31: last valid interval, delta shifts to 0 but still pulses
        do_reset();
        pulse(1'b1, 1'b0); gap(30);
        expect_upd(128, 1, 31, "dt31_zero_delta");
        pulse(1'b0, 1'b1); gap(4);

        // upper clamp: 250 + 16 -> 255
        do_reset();
        load(8'd250);
        chk("load_250", int'(weight), 250);
        pulse(1'b1, 1'b0);
        expect_upd(255, 1, 1, "clamp_hi");
        pulse(1'b0, 1'b1); gap(4);

        // lower clamp: 5 - 16 -> 0
        do_reset();
        load(8'd5);
        pulse(1'b0, 1'b1);
        expect_upd(0, 0, 1, "clamp_lo");
        pulse(1'b1, 1'b0); gap(4);
        chk("clamp_lo_weight", int'(weight), 0);

        // simultaneous spikes: no event; post 3 cycles later pairs with that pre
        do_reset();
        pulse(1'b1, 1'b1); gap(2);
        chk("same_cycle_no_update", int'(weight), 128);
        expect_upd(144, 1, 3, "after_same_cycle");
        pulse(1'b0, 1'b1); gap(4);

        // learn_en low on a valid pair: no update
        do_reset();
        pulse(1'b1, 1'b0); gap(2);
        learn_en = 1'b0;
        pulse(1'b0, 1'b1);
        learn_en = 1'b1;
        gap(4);
        chk("learn_off_weight", int'(weight), 128);

        // back-to-back events: dt=1 then dt=2, each reading the fresh weight
        do_reset();
        pulse(1'b1, 1'b0);
        expect_upd(144, 1, 1, "b2b_first");
        pulse(1'b0, 1'b1);
        expect_upd(160, 1, 2, "b2b_second");
        pulse(1'b0, 1'b1); gap(4);
        chk("b2b_weight", int'(weight), 160);

        // weight load at the stage-2 edge overrides the pending update
        do_reset();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        load(8'd77);
        gap(4);
        chk("load_override", int'(weight), 77);

        // asynchronous reset one cycle after a valid LTP post
        do_reset();
        pulse(1'b1, 1'b0); gap(2);
        pulse(1'b0, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_weight", int'(weight), 128);
        chk("async_rst_valid", int'(update_valid), 0);
        tick();
        rst = 1'b0;
        gap(2);
        pulse(1'b0, 1'b1); gap(4);   // pre counter is saturated: no pairing
        chk("async_rst_cnt_sat", int'(weight), 128);

        gap(2);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
